// File: rtl/dmem_pkg.sv
// Shared defaults, FSM state type and helpers for the data-memory responder.
package dmem_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with a registered read port; the array itself is never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = idxWidth(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-side responder for the DMAR/DMDR interface: latches a request, waits the
// configured number of wait states, performs one RAM access and answers with an ack pulse.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 2**19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int               IDX_W     = idxWidth(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack;
  logic              r_busy;
  logic              r_err;

  logic              w_inRange;
  logic              w_ramEn;
  logic              w_showRam;
  logic [DATA_W-1:0] w_ramQ;

  assign w_inRange = ({1'b0, addr} < DEPTH_L);
  assign w_ramEn   = (r_state == ACCESS);

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk   (clk),
    .i_en    (w_ramEn),
    .i_we    (r_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ramQ)
  );

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_addr  <= addr[IDX_W-1:0];
            r_we    <= we;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            if (!w_inRange) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              r_state <= ACCESS;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACCESS: begin
          r_state <= RESP;
          r_ack   <= 1'b1;
        end
        RESP: begin
          // The RAM's registered read data is shown directly during RESP and kept here afterwards.
          if (!r_we && !r_err) begin
            r_rdata <= w_ramQ;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_showRam = r_ack & ~r_we & ~r_err;
  assign rdata     = w_showRam ? w_ramQ : r_rdata;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (DEPTH=1024/WAIT=1 and full depth/WAIT=0),
// a vector table, hand-written corner sequences and randomized accesses against a memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rstN  [2];
  logic        req   [2];
  logic        we    [2];
  logic [18:0] addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(19), .DATA_W(8), .DEPTH(1024), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .RST_N(rstN[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );

  dmem_ctrl #(.ADDR_W(19), .DATA_W(8), .DEPTH(524288), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .RST_N(rstN[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  function automatic int depthOf(input int d);
    return (d == 0) ? 1024 : 524288;
  endfunction

  function automatic int waitOf(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  typedef struct {
    int          dut;
    logic        w;
    logic [18:0] a;
    logic [7:0]  wd;
    int          lat;
    logic [7:0]  rd;
    logic        e;
  } vec_t;

  vec_t        vecs [15];
  logic [7:0]  model [int];
  logic [7:0]  expRd [2];
  logic [18:0] pool0 [8];
  logic [18:0] pool1 [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic waitIdle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[d] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) reportTimeout($sformatf("idle d%0d", d));
  endtask

  task automatic churnInputs(input int d);
    req[d]   = 1'($urandom);
    we[d]    = 1'($urandom);
    addr[d]  = 19'($urandom);
    wdata[d] = 8'($urandom);
  endtask

  // Issue one request, count edges from acceptance to ack, then drop req as the requester would.
  task automatic applyStimulus(input int d, input logic w, input logic [18:0] a, input logic [7:0] wd,
                               input bit churn, output int lat, output logic [7:0] rd, output logic e);
    bit gotAck;
    waitIdle(d);
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    lat    = 0;
    gotAck = 0;
    while (!gotAck && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack[d] === 1'b1) gotAck = 1;
      else if (churn) churnInputs(d);
    end
    if (!gotAck) reportTimeout($sformatf("ack d%0d addr 0x%0h", d, a));
    rd = rdata[d];
    e  = err[d];
    req[d] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput($sformatf("ack pulse width d%0d", d), 32'(ack[d]), 32'd0);
  endtask

  task automatic resetAll();
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      expRd[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
  endtask

  initial begin
    int          lat;
    logic [7:0]  rd;
    logic        e;

    vecs[0]  = '{0, 1'b1, 19'h00010, 8'hA5, 3, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 19'h00010, 8'h00, 3, 8'hA5, 1'b0};
    vecs[2]  = '{0, 1'b1, 19'h003FF, 8'h5A, 3, 8'hA5, 1'b0};
    vecs[3]  = '{0, 1'b0, 19'h003FF, 8'h00, 3, 8'h5A, 1'b0};
    vecs[4]  = '{0, 1'b0, 19'd1024,  8'h00, 1, 8'h5A, 1'b1};
    vecs[5]  = '{0, 1'b1, 19'h00410, 8'h99, 1, 8'h5A, 1'b1};
    vecs[6]  = '{0, 1'b0, 19'h00010, 8'h00, 3, 8'hA5, 1'b0};
    vecs[7]  = '{0, 1'b1, 19'h00010, 8'hC3, 3, 8'hA5, 1'b0};
    vecs[8]  = '{0, 1'b0, 19'h00010, 8'h00, 3, 8'hC3, 1'b0};
    vecs[9]  = '{0, 1'b1, 19'h00020, 8'h11, 3, 8'hC3, 1'b0};
    vecs[10] = '{0, 1'b0, 19'h7FFFF, 8'h00, 1, 8'hC3, 1'b1};
    vecs[11] = '{1, 1'b1, 19'h7FFFF, 8'h3C, 2, 8'h00, 1'b0};
    vecs[12] = '{1, 1'b0, 19'h7FFFF, 8'h00, 2, 8'h3C, 1'b0};
    vecs[13] = '{1, 1'b1, 19'h00000, 8'hE7, 2, 8'h3C, 1'b0};
    vecs[14] = '{1, 1'b0, 19'h00000, 8'h00, 2, 8'hE7, 1'b0};

    pool0 = '{19'h0, 19'h1, 19'h2, 19'h155, 19'h3FE, 19'h3FF, 19'd1024, 19'h7FFFF};
    pool1 = '{19'h0, 19'h1, 19'h12345, 19'h40000, 19'h7FFFE, 19'h7FFFF, 19'h0ABCD, 19'h55555};

    resetAll();
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset rdata d%0d", d), 32'(rdata[d]), 32'd0);
      checkOutput($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'd0);
      checkOutput($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'd0);
      checkOutput($sformatf("reset err d%0d", d), 32'(err[d]), 32'd0);
    end

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].dut, vecs[i].w, vecs[i].a, vecs[i].wd, 1'b0, lat, rd, e);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].rd));
      checkOutput($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].e));
    end

    // Back-to-back reads with req held high: acks spaced by one access plus one IDLE cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, 19'(k), 8'(k), 1'b0, lat, rd, e);
      checkOutput($sformatf("preload%0d latency", k), 32'(lat), 32'd3);
    end
    begin
      int cyc, prev, k;
      waitIdle(0);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'd0;
      cyc = 0; prev = 0; k = 0;
      while (k < 4 && cyc < 100) begin
        @(posedge clk);
        #1;
        cyc++;
        if (k > 0 && cyc == prev + 1)
          checkOutput($sformatf("b2b idle gap busy %0d", k), 32'(busy[0]), 32'd0);
        if (ack[0] === 1'b1) begin
          checkOutput($sformatf("b2b rdata %0d", k), 32'(rdata[0]), 32'(k));
          checkOutput($sformatf("b2b spacing %0d", k), 32'(cyc - prev), (k == 0) ? 32'd3 : 32'd4);
          prev = cyc;
          k++;
          if (k < 4) addr[0] = 19'(k);
          else req[0] = 1'b0;
        end
      end
      if (k < 4) reportTimeout("b2b acks");
      req[0] = 1'b0;
    end

    // Asynchronous reset between edges while in WAIT: outputs clear at once, no write lands.
    waitIdle(0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 19'h00020; wdata[0] = 8'h77;
    @(posedge clk);
    #2;
    rstN[0] = 1'b0;
    req[0]  = 1'b0;
    #1;
    checkOutput("async reset rdata", 32'(rdata[0]), 32'd0);
    checkOutput("async reset ack", 32'(ack[0]), 32'd0);
    checkOutput("async reset busy", 32'(busy[0]), 32'd0);
    checkOutput("async reset err", 32'(err[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstN[0] = 1'b1;
    applyStimulus(0, 1'b0, 19'h00020, 8'h00, 1'b0, lat, rd, e);
    checkOutput("no write after reset latency", 32'(lat), 32'd3);
    checkOutput("no write after reset rdata", 32'(rd), 32'h11);

    // Inputs churned every cycle after acceptance must not affect the latched access.
    applyStimulus(0, 1'b1, 19'h00030, 8'h5E, 1'b1, lat, rd, e);
    checkOutput("churn write latency", 32'(lat), 32'd3);
    applyStimulus(0, 1'b0, 19'h00030, 8'h00, 1'b1, lat, rd, e);
    checkOutput("churn read rdata", 32'(rd), 32'h5E);
    checkOutput("churn read err", 32'(e), 32'd0);

    resetAll();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        logic [18:0] a;
        logic        w;
        logic [7:0]  wd;
        bit          oor;
        int          key;
        a   = (d == 0) ? pool0[$urandom_range(0, 7)] : pool1[$urandom_range(0, 7)];
        oor = (int'(a) >= depthOf(d));
        key = d * (1 << 20) + int'(a);
        w   = 1'($urandom);
        if (!w && !oor && !model.exists(key)) w = 1'b1;
        wd  = 8'($urandom);
        applyStimulus(d, w, a, wd, 1'($urandom), lat, rd, e);
        if (!oor && w) model[key] = wd;
        if (!oor && !w) expRd[d] = model[key];
        checkOutput($sformatf("rand d%0d #%0d latency", d, i), 32'(lat), oor ? 32'd1 : 32'(waitOf(d) + 2));
        checkOutput($sformatf("rand d%0d #%0d rdata", d, i), 32'(rd), 32'(expRd[d]));
        checkOutput($sformatf("rand d%0d #%0d err", d, i), 32'(e), 32'(oor));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
